chip_shift_driver: RTL and testbench

CHIP_SHIFT_DRIVER -- requirements
Module: chip_shift_driver

---
 rtl/chip_drv_pkg.sv | 21 ++
 rtl/chip_clk_div.sv | 30 +++
 rtl/chip_shift_driver.sv | 172 +++++++++++++++++
 tb/tb_chip_shift_driver.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chip_drv_pkg.sv
// Shared command encoding, FSM state type and widths for the chip shift-chain driver.
package chip_drv_pkg;

    localparam int unsigned CMD_W = 2;

    typedef enum logic [CMD_W-1:0] {
        CMD_COL = 2'b00,
        CMD_ROW = 2'b01,
        CMD_KEY = 2'b10,
        CMD_NOP = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        KEY      = 3'd3,
        DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/chip_clk_div.sv
// Divider tick generator: one tick every div+1 clk cycles, counter cleared by restart.
module chip_clk_div #(
    parameter int unsigned DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == div);
        cnt_d = cnt_q + DIV_W'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/chip_shift_driver.sv
// Serial shift-chain driver for chip column/row registers plus latch strobe.
// Build option: CHIP_DRV_AUTO_KEY_EN appends a write-key strobe after every row load.
module chip_shift_driver
    import chip_drv_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DIV_W     = 24,
    parameter int unsigned KEY_TICKS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [CMD_W-1:0]             i_cmd,
    input  logic [DATA_W-1:0]            i_data,
    input  logic [$clog2(DATA_W+1)-1:0]  i_len,
    input  logic [DIV_W-1:0]             i_clk_div,
    output logic                         o_clk_col,
    output logic                         o_data_col,
    output logic                         o_clk_row,
    output logic                         o_data_row,
    output logic                         o_write_key,
    output logic                         o_done
);

    localparam int unsigned LEN_W = $clog2(DATA_W + 1);
    localparam int unsigned KEY_W = (KEY_TICKS > 1) ? $clog2(KEY_TICKS) : 1;

`ifdef CHIP_DRV_AUTO_KEY_EN
    localparam bit AUTO_KEY = 1'b1;
`else
    localparam bit AUTO_KEY = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               row_q, row_d;
    logic [LEN_W-1:0]   len_c;
    logic               accept;
    logic               restart;
    logic               tick;
    logic [DATA_W-1:0]  data_sh;
    logic               bit_d;
    logic               shift_d;

    logic clk_col_q, data_col_q, clk_row_q, data_row_q, write_key_q, done_q, ready_q;

    chip_clk_div #(.DIV_W(DIV_W)) u_clk_div (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .div     (div_q),
        .tick    (tick)
    );

    assign len_c  = (i_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : i_len;
    assign accept = i_valid && ready_q && (state_q == IDLE);

    // Next-state logic; everything about the command is captured at accept.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        key_d   = key_q;
        div_d   = div_q;
        row_d   = row_q;
        restart = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    restart = 1'b1;
                    div_d   = i_clk_div;
                    data_d  = i_data;
                    row_d   = (cmd_e'(i_cmd) == CMD_ROW);
                    case (cmd_e'(i_cmd))
                        CMD_COL, CMD_ROW: begin
                            if (len_c == '0) begin
                                state_d = DONE;
                            end else begin
                                idx_d   = len_c - LEN_W'(1);
                                state_d = SHIFT_LO;
                            end
                        end
                        CMD_KEY: begin
                            key_d   = KEY_W'(KEY_TICKS - 1);
                            state_d = KEY;
                        end
                        default: state_d = DONE;
                    endcase
                end
            end
            SHIFT_LO: begin
                if (tick) state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (tick) begin
                    if (idx_q != '0) begin
                        idx_d   = idx_q - LEN_W'(1);
                        state_d = SHIFT_LO;
                    end else if (row_q && AUTO_KEY) begin
                        key_d   = KEY_W'(KEY_TICKS - 1);
                        state_d = KEY;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            KEY: begin
                if (tick) begin
                    if (key_q == '0) begin
                        state_d = DONE;
                    end else begin
                        key_d = key_q - KEY_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_comb begin
        data_sh = data_d >> idx_d;
        bit_d   = data_sh[0];
        shift_d = (state_d == SHIFT_LO) || (state_d == SHIFT_HI);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            idx_q       <= '0;
            key_q       <= '0;
            div_q       <= '0;
            row_q       <= 1'b0;
            clk_col_q   <= 1'b0;
            data_col_q  <= 1'b0;
            clk_row_q   <= 1'b0;
            data_row_q  <= 1'b0;
            write_key_q <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            idx_q       <= idx_d;
            key_q       <= key_d;
            div_q       <= div_d;
            row_q       <= row_d;
            clk_col_q   <= (state_d == SHIFT_HI) && !row_d;
            data_col_q  <= shift_d && !row_d && bit_d;
            clk_row_q   <= (state_d == SHIFT_HI) && row_d;
            data_row_q  <= shift_d && row_d && bit_d;
            write_key_q <= (state_d == KEY);
            done_q      <= (state_d == DONE);
            ready_q     <= (state_d == IDLE);
        end
    end

    assign o_clk_col   = clk_col_q;
    assign o_data_col  = data_col_q;
    assign o_clk_row   = clk_row_q;
    assign o_data_row  = data_row_q;
    assign o_write_key = write_key_q;
    assign o_done      = done_q;
    assign o_ready     = ready_q;

endmodule

// File: tb/tb_chip_shift_driver.sv
// Scoreboard bench for chip_shift_driver: driver pushes expected transactions, negedge monitor checks them.
module tb_chip_shift_driver;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned DIV_W     = 24;
    localparam int unsigned KEY_TICKS = 2;
    localparam int unsigned LEN_W     = $clog2(DATA_W + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_valid = 1'b0;
    logic              o_ready;
    logic [1:0]        i_cmd = 2'b11;
    logic [DATA_W-1:0] i_data = '0;
    logic [LEN_W-1:0]  i_len = '0;
    logic [DIV_W-1:0]  i_clk_div = '0;
    logic o_clk_col, o_data_col, o_clk_row, o_data_row, o_write_key, o_done;

    chip_shift_driver #(.DATA_W(DATA_W), .DIV_W(DIV_W), .KEY_TICKS(KEY_TICKS)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_cmd(i_cmd),
        .i_data(i_data), .i_len(i_len), .i_clk_div(i_clk_div),
        .o_clk_col(o_clk_col), .o_data_col(o_data_col), .o_clk_row(o_clk_row),
        .o_data_row(o_data_row), .o_write_key(o_write_key), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        int          nbits;
        logic [31:0] bits;
        int          width;
        bit          row;
        int          keyc;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Monitor state, rebuilt per transaction from observed pins only.
    bit          active = 0;
    bit          chk_rdy = 0;
    int          acc = 0;
    int          cn, rn, crun, rrun, cmin, cmax, rmin, rmax, cdh, rdh, keyc, rdylow, unstable;
    logic [31:0] cb, rb;
    logic        pc = 0, pdc = 0, pr = 0, pdr = 0;

    task automatic clear_mon();
        cn = 0; rn = 0; crun = 0; rrun = 0; cdh = 0; rdh = 0; keyc = 0; rdylow = 0; unstable = 0;
        cmin = 1 << 30; rmin = 1 << 30; cmax = 0; rmax = 0; cb = '0; rb = '0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            active = 0; chk_rdy = 0; clear_mon();
            pc = 0; pdc = 0; pr = 0; pdr = 0;
        end else begin
            if (chk_rdy) begin
                chk("ready_after_done", o_ready, 1);
                chk_rdy = 0;
            end
            if (active) begin
                if (o_clk_col && (!pc || pdc != o_data_col)) unstable += (pdc != o_data_col) ? 1 : 0;
                if (o_clk_col && !pc) begin cb = {cb[30:0], o_data_col}; cn++; end
                if (o_clk_col) crun++;
                else if (pc) begin
                    if (crun < cmin) cmin = crun;
                    if (crun > cmax) cmax = crun;
                    crun = 0;
                end
                if (o_clk_row && (pdr != o_data_row)) unstable++;
                if (o_clk_row && !pr) begin rb = {rb[30:0], o_data_row}; rn++; end
                if (o_clk_row) rrun++;
                else if (pr) begin
                    if (rrun < rmin) rmin = rrun;
                    if (rrun > rmax) rmax = rrun;
                    rrun = 0;
                end
                if (o_data_col) cdh++;
                if (o_data_row) rdh++;
                if (o_write_key) keyc++;
                if (!o_ready) rdylow++;
                if (o_done) begin
                    exp_t e;
                    chk("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("latency", cyc - acc, e.lat);
                        chk("key_cycles", keyc, e.keyc);
                        chk("ready_low_cycles", rdylow, e.lat);
                        chk("data_unstable", unstable, 0);
                        chk("data_at_done", {o_data_col, o_data_row}, 0);
                        if (e.row) begin
                            chk("row_nbits", rn, e.nbits);
                            chk("row_bits", rb, e.bits);
                            chk("col_pulses_idle", cn, 0);
                            chk("col_data_idle", cdh, 0);
                            if (e.nbits > 0) begin
                                chk("row_width_min", rmin, e.width);
                                chk("row_width_max", rmax, e.width);
                            end
                        end else begin
                            chk("col_nbits", cn, e.nbits);
                            chk("col_bits", cb, e.bits);
                            chk("row_pulses_idle", rn, 0);
                            chk("row_data_idle", rdh, 0);
                            if (e.nbits > 0) begin
                                chk("col_width_min", cmin, e.width);
                                chk("col_width_max", cmax, e.width);
                            end
                        end
                    end
                    active = 0;
                    chk_rdy = 1;
                    done_cnt++;
                end
            end
            if (!active && i_valid && o_ready) begin
                active = 1;
                acc = cyc;
                clear_mon();
            end
            pc = o_clk_col; pdc = o_data_col; pr = o_clk_row; pdr = o_data_row;
        end
    end

    task automatic scramble();
        i_cmd = 2'($urandom); i_data = DATA_W'($urandom);
        i_len = LEN_W'($urandom); i_clk_div = DIV_W'($urandom);
    endtask

    // Reference: behaviour derived directly from the command rules, not from the FSM.
    task automatic issue(input logic [1:0] cmd, input logic [DATA_W-1:0] data,
                         input int len, input int div, input bit push);
        exp_t e;
        int L, p, target;
        bit ok;
        logic [31:0] m;
        L = (len > DATA_W) ? DATA_W : len;
        p = div + 1;
        e.width = p; e.row = (cmd == 2'b01); e.nbits = 0; e.bits = '0; e.keyc = 0; e.lat = 1;
        if ((cmd == 2'b00 || cmd == 2'b01) && L > 0) begin
            m = (32'h1 << L) - 32'h1;
            e.nbits = L;
            e.bits  = {16'h0, data} & m;
            e.lat   = 2 * L * p + 1;
`ifdef CHIP_DRV_AUTO_KEY_EN
            if (cmd == 2'b01) begin
                e.keyc = KEY_TICKS * p;
                e.lat  = e.lat + e.keyc;
            end
`endif
        end else if (cmd == 2'b10) begin
            e.keyc = KEY_TICKS * p;
            e.lat  = e.keyc + 1;
        end
        if (push) sb.push_back(e);
        target = done_cnt + 1;
        @(posedge clk); #1;
        i_cmd = cmd; i_data = data; i_len = LEN_W'(len); i_clk_div = DIV_W'(div); i_valid = 1'b1;
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (o_ready) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        if (push) begin
            ok = 0;
            for (int t = 0; t < 2000; t++) begin
                scramble();
                if (done_cnt >= target) begin ok = 1; break; end
                @(posedge clk); #1;
            end
            if (!ok) chk("done_timeout", 0, 1);
        end
    endtask

    task automatic check_all_low(input string tag);
        chk({tag, "_outs"}, {o_clk_col, o_data_col, o_clk_row, o_data_row, o_write_key, o_done}, 0);
    endtask

    initial begin
        bit ok;
        #1;
        check_all_low("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", o_ready, 1);

        issue(2'b00, 16'hA5C3, 16, 3, 1);
        issue(2'b01, 16'h0005, 3, 0, 1);
        issue(2'b10, 16'h0000, 0, 1, 1);
        issue(2'b00, 16'hFFFF, 0, 2, 1);
        issue(2'b11, 16'h1234, 9, 3, 1);
        issue(2'b00, 16'h3C5A, 20, 1, 1);
        issue(2'b01, 16'h8001, 16, 0, 1);

        // Reset in the middle of a col load, after the 5th bit has been clocked.
        issue(2'b00, 16'hBEEF, 16, 2, 0);
        ok = 0;
        for (int t = 0; t < 500; t++) begin
            @(posedge clk); #1;
            scramble();
            if (cn >= 5 && !o_clk_col) begin ok = 1; break; end
        end
        if (!ok) chk("mid_reset_timeout", 0, 1);
        #2 rst = 1'b0;
        #1 check_all_low("mid_reset");
        repeat (2) @(posedge clk);
        #1 check_all_low("mid_reset_hold");
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_mid_reset", o_ready, 1);
        issue(2'b00, 16'hA5C3, 16, 0, 1);

        for (int n = 0; n < 40; n++) begin
            issue(2'($urandom_range(0, 3)), DATA_W'($urandom), int'($urandom_range(0, 20)),
                  int'($urandom_range(0, 3)), 1);
        end
        repeat (3) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
